load_store_unit: RTL and testbench

//  Memory-access stage of the multi-cycle RV32I core; consumes the ALU effective

---
 rtl/load_store_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage of the multi-cycle RV32I core.
// Takes the effective address and rs2 value from execute and issues one
// aligned-word bus transaction per load or store with byte strobes. Load data
// is extracted and sign- or zero-extended. Misalignment, illegal funct3 and
// bus timeout are reported to the control FSM alongside a one-cycle done pulse.
//
// Ports
//   clk, rst        core clock, synchronous active-high reset
//   start           1-cycle pulse: begin access (ignored unless idle)
//   is_load         decoded load
//   is_store        decoded store
//   funct3          access width / signedness
//   address         effective address (rs1 + imm)
//   store_data      rs2 value
//   mem_req         bus request, held until mem_ready
//   mem_we          1 = write
//   mem_addr        word-aligned address
//   mem_wdata       lane-replicated store data
//   mem_wstrb       byte enables (0000 on reads)
//   mem_ready       bus accept/complete; mem_rdata valid same cycle on reads
//   mem_rdata       read word
//   load_result     extended load value, held until the next successful load
//   done            1-cycle pulse when the access finishes (ok or fault)
//   misaligned      with done: misaligned address or illegal funct3
//   bus_err         with done: bus timeout
//   busy            high whenever the unit is not idle
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_result,
    output logic        done,
    output logic        misaligned,
    output logic        bus_err,
    output logic        busy
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic               lat_load, lat_load_nxt;
    logic [2:0]         lat_f3, lat_f3_nxt;
    logic [1:0]         lat_off, lat_off_nxt;

    logic               req_nxt;
    logic               we_nxt;
    logic [DATA_W-1:0]  addr_nxt;
    logic [DATA_W-1:0]  wdata_nxt;
    logic [3:0]         wstrb_nxt;
    logic [DATA_W-1:0]  result_nxt;
    logic               done_nxt;
    logic               mis_nxt;
    logic               berr_nxt;

    // Request decode from the raw inputs, used only in IDLE on start
    logic               f3_legal_c;
    logic               addr_misaligned_c;
    logic [DATA_W-1:0]  st_wdata_c;
    logic [3:0]         st_wstrb_c;

    always_comb begin
        f3_legal_c = 1'b0;
        if (is_load) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal_c = 1'b1;
                default:                                f3_legal_c = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010: f3_legal_c = 1'b1;
                default:                f3_legal_c = 1'b0;
            endcase
        end

        addr_misaligned_c = ((funct3[1:0] == 2'b01) && address[0]) ||
                            ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));

        case (funct3[1:0])
            2'b00: begin
                st_wdata_c = {4{store_data[7:0]}};
                st_wstrb_c = 4'b0001 << address[1:0];
            end
            2'b01: begin
                st_wdata_c = {2{store_data[15:0]}};
                st_wstrb_c = 4'b0011 << address[1:0];
            end
            default: begin
                st_wdata_c = store_data;
                st_wstrb_c = 4'b1111;
            end
        endcase
    end

    // Load lane extraction from the latched width and byte offset
    logic [DATA_W-1:0] rd_shift_c;
    logic [DATA_W-1:0] ld_ext_c;

    always_comb begin
        rd_shift_c = mem_rdata >> {lat_off, 3'b000};
        case (lat_f3)
            3'b000:  ld_ext_c = {{24{rd_shift_c[7]}},  rd_shift_c[7:0]};
            3'b001:  ld_ext_c = {{16{rd_shift_c[15]}}, rd_shift_c[15:0]};
            3'b100:  ld_ext_c = {24'd0, rd_shift_c[7:0]};
            3'b101:  ld_ext_c = {16'd0, rd_shift_c[15:0]};
            default: ld_ext_c = rd_shift_c;
        endcase
    end

    // Timeout fires on the wait cycle that brings the count up to TIMEOUT
    logic timeout_hit_c;
    assign timeout_hit_c = ((32'(wait_cnt) + 32'd1) >= 32'(TIMEOUT));

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        lat_load_nxt = lat_load;
        lat_f3_nxt   = lat_f3;
        lat_off_nxt  = lat_off;
        req_nxt      = 1'b0;
        we_nxt       = 1'b0;
        addr_nxt     = '0;
        wdata_nxt    = '0;
        wstrb_nxt    = 4'b0000;
        result_nxt   = load_result;
        done_nxt     = 1'b0;
        mis_nxt      = 1'b0;
        berr_nxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    lat_load_nxt = is_load;
                    lat_f3_nxt   = funct3;
                    lat_off_nxt  = address[1:0];
                    if (is_load == is_store) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end else if (!f3_legal_c || addr_misaligned_c) begin
                        state_nxt = ST_FAULT;
                        done_nxt  = 1'b1;
                        mis_nxt   = 1'b1;
                    end else begin
                        state_nxt    = ST_BUS;
                        wait_cnt_nxt = '0;
                        req_nxt      = 1'b1;
                        we_nxt       = is_store;
                        addr_nxt     = {address[31:2], 2'b00};
                        wdata_nxt    = is_store ? st_wdata_c : '0;
                        wstrb_nxt    = is_store ? st_wstrb_c : 4'b0000;
                    end
                end
            end

            ST_BUS: begin
                if (mem_ready) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                    if (lat_load) begin
                        result_nxt = ld_ext_c;
                    end
                end else if (timeout_hit_c) begin
                    state_nxt = ST_FAULT;
                    done_nxt  = 1'b1;
                    berr_nxt  = 1'b1;
                end else begin
                    wait_cnt_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + 16'd1;
                    req_nxt      = 1'b1;
                    we_nxt       = mem_we;
                    addr_nxt     = mem_addr;
                    wdata_nxt    = mem_wdata;
                    wstrb_nxt    = mem_wstrb;
                end
            end

            ST_DONE:  state_nxt = ST_IDLE;
            ST_FAULT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State, latched request and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            lat_load    <= 1'b0;
            lat_f3      <= 3'b000;
            lat_off     <= 2'b00;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= 4'b0000;
            load_result <= '0;
            done        <= 1'b0;
            misaligned  <= 1'b0;
            bus_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            lat_load    <= lat_load_nxt;
            lat_f3      <= lat_f3_nxt;
            lat_off     <= lat_off_nxt;
            mem_req     <= req_nxt;
            mem_we      <= we_nxt;
            mem_addr    <= addr_nxt;
            mem_wdata   <= wdata_nxt;
            mem_wstrb   <= wstrb_nxt;
            load_result <= result_nxt;
            done        <= done_nxt;
            misaligned  <= mis_nxt;
            bus_err     <= berr_nxt;
            busy        <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized accesses checked
// against a behavioural model of the access rules.
module tb_load_store_unit;

    localparam int unsigned TMO = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] load_result;
    logic        done;
    logic        misaligned;
    logic        bus_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_result = 32'd0;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load),
        .is_store(is_store), .funct3(funct3), .address(address),
        .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .load_result(load_result), .done(done), .misaligned(misaligned),
        .bus_err(bus_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: legality of the request
    function automatic bit ref_legal(input bit ld, input logic [2:0] f3);
        if (ld) return (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        return (f3 == 0 || f3 == 1 || f3 == 2);
    endfunction

    function automatic int ref_size(input logic [2:0] f3);
        return 1 << (f3 % 4);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] w;
        w = rd >> (8 * (a % 4));
        case (f3)
            3'd0: begin w = w % 256;   if (w >= 128)   w = w - 256;   end
            3'd1: begin w = w % 65536; if (w >= 32768) w = w - 65536; end
            3'd4: w = w % 256;
            3'd5: w = w % 65536;
            default: ;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (ref_size(f3) == 1) return (d % 256) * 32'h0101_0101;
        if (ref_size(f3) == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_wstrb(input logic [2:0] f3, input logic [31:0] a);
        if (ref_size(f3) == 1) return 32'(1 << (a % 4));
        if (ref_size(f3) == 2) return 32'(3 << (a % 4));
        return 32'd15;
    endfunction

    // One access; waitc = mem_ready-low cycles before accept (>= TMO means timeout)
    task automatic access(input string tag, input bit ld, input bit st,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rd,
                          input int waitc, input bit poke_start);
        bit nobus, fault, tmo;
        int reqc;
        nobus = (ld == st);
        fault = !nobus && (!ref_legal(ld, f3) || (a % ref_size(f3)) != 0);
        tmo   = !nobus && !fault && (waitc >= int'(TMO));
        reqc  = tmo ? int'(TMO) : waitc + 1;

        @(negedge clk);
        start = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        address = a; store_data = d; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        is_load = 1'($urandom); is_store = 1'($urandom);
        address = $urandom; store_data = $urandom;

        if (!nobus && !fault) begin
            for (int k = 0; k < reqc; k++) begin
                chk({tag, " req"}, 32'(mem_req), 32'd1);
                chk({tag, " we"}, 32'(mem_we), 32'(st));
                chk({tag, " addr"}, mem_addr, a - (a % 4));
                chk({tag, " wstrb"}, 32'(mem_wstrb), st ? ref_wstrb(f3, a) : 32'd0);
                if (st) chk({tag, " wdata"}, mem_wdata, ref_wdata(f3, d));
                chk({tag, " early done"}, 32'(done), 32'd0);
                if (poke_start && k == 0) begin
                    start = 1'b1; is_load = 1'b1; is_store = 1'b0;
                    funct3 = 3'b010; address = 32'h0000_0100;
                end
                mem_ready = (k == waitc);
                mem_rdata = (k == waitc) ? rd : $urandom;
                @(negedge clk);
                start = 1'b0;
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
            if (ld && !tmo) model_result = ref_load(f3, a, rd);
        end

        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " req off"}, 32'(mem_req), 32'd0);
        chk({tag, " misaligned"}, 32'(misaligned), 32'(fault));
        chk({tag, " bus_err"}, 32'(bus_err), 32'(tmo));
        chk({tag, " busy"}, 32'(busy), 32'd1);
        chk({tag, " result"}, load_result, model_result);
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(done), 32'd0);
        chk({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = 3'b000; address = 32'd0; store_data = 32'd0;
        mem_ready = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst req", 32'(mem_req), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst result", load_result, 32'd0);
        chk("rst wstrb", 32'(mem_wstrb), 32'd0);
        rst = 1'b0;

        access("sw",  1'b0, 1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'd0, 0, 1'b0);
        access("lb",  1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'd0, 32'h80FF_1122, 0, 1'b0);
        chk("lb value", load_result, 32'hFFFF_FF80);
        access("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_2003, 32'd0, 32'h80FF_1122, 0, 1'b0);
        chk("lbu value", load_result, 32'h0000_0080);
        access("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'd0, 32'h80FF_1122, 0, 1'b0);
        chk("lhu value", load_result, 32'h0000_80FF);
        access("sh mis", 1'b0, 1'b1, 3'b001, 32'h0000_3001, 32'h1234, 32'd0, 0, 1'b0);
        access("ld f3=3", 1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'd0, 32'd0, 0, 1'b0);
        access("ld tmo", 1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0, 32'h5555_5555, 1000, 1'b0);
        chk("tmo keeps result", load_result, 32'h0000_80FF);
        access("sb wait", 1'b0, 1'b1, 3'b000, 32'h0000_0007, 32'h0000_00AB, 32'd0, 3, 1'b1);
        access("neither", 1'b0, 1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'd0, 0, 1'b0);
        access("both", 1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'd0, 32'd0, 0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            int sel;
            bit ld, st;
            logic [31:0] a;
            sel = int'($urandom_range(0, 9));
            ld = (sel < 5) || (sel == 9);
            st = (sel >= 5);
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a = a & 32'hFFFF_FFFC;
            access("rand", ld, st, 3'($urandom), a, $urandom, $urandom,
                   int'($urandom_range(0, 5)), 1'($urandom));
        end

        // Make sure there is a non-zero result to clear
        access("pre rst", 1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'd0, 32'hCAFE_F00D, 0, 1'b0);
        @(negedge clk);
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
        address = 32'h0000_0080;
        @(negedge clk);
        start = 1'b0;
        chk("rst mid req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort req", 32'(mem_req), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort result", load_result, 32'd0);
        chk("abort addr", mem_addr, 32'd0);
        chk("abort flags", {30'd0, misaligned, bus_err}, 32'd0);
        rst = 1'b0;
        model_result = 32'd0;
        @(negedge clk);
        chk("no late done", 32'(done), 32'd0);
        access("post rst", 1'b1, 1'b0, 3'b001, 32'h0000_0042, 32'd0, 32'h8001_0000, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
